// File: rtl/poly_tile_fifo.sv
// poly_tile_fifo: show-ahead tile buffer between the polynomial multiplier
// and relin_unit. Each stored tile carries its position inside its polynomial
// so the consumer can see the last tile and a completion pulse.
module poly_tile_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int TILE_WIDTH = 8,
    parameter int POLY_WIDTH = 512,
    parameter int DEPTH      = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enqueue,
    input  logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] in_tile,
    output logic                                  full,
    output logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] out_tile,
    output logic                                  inputs_ready_signal,
    input  logic                                  dequeue,
    output logic [$clog2(DEPTH):0]                count,
    output logic [$clog2(POLY_WIDTH/TILE_WIDTH)-1:0] tile_index,
    output logic                                  last_tile,
    output logic                                  poly_done,
    output logic                                  overflow,
    output logic                                  underflow
);

    localparam int TILES_PER_POLY = POLY_WIDTH / TILE_WIDTH;
    localparam int PTR_W          = $clog2(DEPTH);
    localparam int CNT_W          = PTR_W + 1;
    localparam int IDX_W          = $clog2(TILES_PER_POLY);

    logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]                      tag_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] widx_q, widx_d;
    logic             poly_done_q, poly_done_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic notEmpty;
    logic wrOk;
    logic rdOk;

    // Status and show-ahead head view; an empty FIFO presents zeros.
    always_comb begin
        full                = (count_q == CNT_W'(DEPTH));
        notEmpty            = (count_q != '0);
        inputs_ready_signal = notEmpty;
        out_tile            = notEmpty ? mem_q[rd_ptr_q] : '0;
        tile_index          = notEmpty ? tag_q[rd_ptr_q] : '0;
        last_tile           = notEmpty && (tag_q[rd_ptr_q] == IDX_W'(TILES_PER_POLY - 1));
        count               = count_q;
        poly_done           = poly_done_q;
        overflow            = overflow_q;
        underflow           = underflow_q;
    end

    // Accept decisions use the pre-pop state, so a full FIFO rejects a
    // simultaneous write and an empty FIFO ignores a simultaneous read.
    always_comb begin
        wrOk        = enqueue && !full;
        rdOk        = dequeue && notEmpty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        widx_d      = widx_q;
        overflow_d  = overflow_q || (enqueue && full);
        underflow_d = underflow_q || (dequeue && !notEmpty);
        poly_done_d = rdOk && last_tile;
        if (wrOk) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            widx_d   = (widx_q == IDX_W'(TILES_PER_POLY - 1)) ? '0 : widx_q + IDX_W'(1);
        end
        if (rdOk) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wrOk && !rdOk) begin
            count_d = count_q + CNT_W'(1);
        end else if (rdOk && !wrOk) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state; reset discards all buffered tiles and restarts indexing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            widx_q      <= '0;
            poly_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            widx_q      <= widx_d;
            poly_done_q <= poly_done_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Tile storage with its polynomial-relative tag; contents survive reset.
    always_ff @(posedge clk) begin
        if (wrOk) begin
            mem_q[wr_ptr_q] <= in_tile;
            tag_q[wr_ptr_q] <= widx_q;
        end
    end

endmodule

// File: tb/tb_poly_tile_fifo.sv
// tb_poly_tile_fifo: directed vector table plus model-checked sequences for
// poly_tile_fifo (back-to-back polynomials, full/empty corners, reset, random).
module tb_poly_tile_fifo;

    typedef logic [7:0][63:0] tile_t;

    typedef struct {
        bit enq;
        bit deq;
        int k;
        int expCount;
        bit expReady;
        bit expFull;
        int expHeadK;
        int expIdx;
        bit expOvf;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        enqueue;
    tile_t       in_tile;
    logic        full;
    tile_t       out_tile;
    logic        inputs_ready_signal;
    logic        dequeue;
    logic [4:0]  count;
    logic [5:0]  tile_index;
    logic        last_tile;
    logic        poly_done;
    logic        overflow;
    logic        underflow;

    int testsRun  = 0;
    int failCount = 0;

    vec_t vecs[$];

    int mCount;
    int mWidx;
    int qK[$];
    int qTag[$];
    bit mOvf;
    bit mUnd;
    int pdSeen;

    poly_tile_fifo #(
        .DATA_WIDTH(64),
        .TILE_WIDTH(8),
        .POLY_WIDTH(512),
        .DEPTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enqueue(enqueue),
        .in_tile(in_tile),
        .full(full),
        .out_tile(out_tile),
        .inputs_ready_signal(inputs_ready_signal),
        .dequeue(dequeue),
        .count(count),
        .tile_index(tile_index),
        .last_tile(last_tile),
        .poly_done(poly_done),
        .overflow(overflow),
        .underflow(underflow)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic tile_t makeTile(input int k);
        tile_t t;
        for (int i = 0; i < 8; i++) begin
            t[i] = 64'(64 * k + i + 1);
        end
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkTile(input string name, input tile_t act, input tile_t exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and sample just after the edge.
    task automatic applyStimulus(input bit enq, input bit deq, input int k);
        enqueue = enq;
        dequeue = deq;
        in_tile = makeTile(k);
        @(posedge clk);
        #1;
        enqueue = 1'b0;
        dequeue = 1'b0;
    endtask

    task automatic addVec(input bit enq, input bit deq, input int k, input int cnt,
                          input bit rdy, input bit ful, input int headK, input int idx,
                          input bit ovf);
        vec_t v;
        v.enq = enq; v.deq = deq; v.k = k; v.expCount = cnt; v.expReady = rdy;
        v.expFull = ful; v.expHeadK = headK; v.expIdx = idx; v.expOvf = ovf;
        vecs.push_back(v);
    endtask

    task automatic resetModel();
        mCount = 0;
        mWidx  = 0;
        qK.delete();
        qTag.delete();
        mOvf   = 1'b0;
        mUnd   = 1'b0;
    endtask

    // One cycle against a behavioural FIFO model of tiles and their tags.
    task automatic stepModel(input bit enq, input bit deq, input int k);
        bit wrOk;
        bit rdOk;
        bit expPd;
        tile_t expTile;
        wrOk  = enq && (mCount < 16);
        rdOk  = deq && (mCount > 0);
        expPd = rdOk && (qTag[0] == 63);
        if (enq && mCount == 16) mOvf = 1'b1;
        if (deq && mCount == 0) mUnd = 1'b1;
        if (rdOk) begin
            void'(qK.pop_front());
            void'(qTag.pop_front());
        end
        if (wrOk) begin
            qK.push_back(k);
            qTag.push_back(mWidx);
            mWidx = (mWidx + 1) % 64;
        end
        mCount = qK.size();
        applyStimulus(enq, deq, k);
        expTile = (mCount > 0) ? makeTile(qK[0]) : '0;
        checkOutput("m_count", count, mCount);
        checkOutput("m_ready", inputs_ready_signal, mCount > 0);
        checkOutput("m_full", full, mCount == 16);
        checkTile("m_out_tile", out_tile, expTile);
        checkOutput("m_tile_index", tile_index, (mCount > 0) ? qTag[0] : 0);
        checkOutput("m_last_tile", last_tile, (mCount > 0) && (qTag[0] == 63));
        checkOutput("m_poly_done", poly_done, expPd);
        checkOutput("m_overflow", overflow, mOvf);
        checkOutput("m_underflow", underflow, mUnd);
        if (poly_done) pdSeen++;
    endtask

    // Asynchronous reset pulse taken away from the clock edge.
    task automatic doReset();
        enqueue = 1'b0;
        dequeue = 1'b0;
        rst     = 1'b0;
        #1;
        checkOutput("rst_async_count", count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        resetModel();
    endtask

    // Main test sequence.
    initial begin
        rst     = 1'b1;
        enqueue = 1'b0;
        dequeue = 1'b0;
        in_tile = '0;
        #2;
        rst = 1'b0;
        #20;
        checkOutput("reset_count", count, 0);
        checkOutput("reset_ready", inputs_ready_signal, 0);
        checkOutput("reset_full", full, 0);
        checkOutput("reset_last", last_tile, 0);
        checkOutput("reset_poly_done", poly_done, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_underflow", underflow, 0);
        checkOutput("reset_tile_index", tile_index, 0);
        checkTile("reset_out_tile", out_tile, '0);
        @(negedge clk);
        rst = 1'b1;

        // Three writes then three pops, followed by fill, overflow and drain.
        addVec(1, 0, 0, 1, 1, 0, 0, 0, 0);
        addVec(1, 0, 1, 2, 1, 0, 0, 0, 0);
        addVec(1, 0, 2, 3, 1, 0, 0, 0, 0);
        addVec(0, 1, 0, 2, 1, 0, 1, 1, 0);
        addVec(0, 1, 0, 1, 1, 0, 2, 2, 0);
        addVec(0, 1, 0, 0, 0, 0, -1, 0, 0);
        for (int j = 0; j < 16; j++) begin
            addVec(1, 0, 100 + j, j + 1, 1, j == 15, 100, 3, 0);
        end
        addVec(1, 0, 200, 16, 1, 1, 100, 3, 1);
        for (int j = 1; j <= 16; j++) begin
            addVec(0, 1, 0, 16 - j, j < 16, 0, (j < 16) ? 100 + j : -1,
                   (j < 16) ? 3 + j : 0, 1);
        end

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].enq, vecs[n].deq, vecs[n].k);
            checkOutput($sformatf("vec%0d_count", n), count, vecs[n].expCount);
            checkOutput($sformatf("vec%0d_ready", n), inputs_ready_signal, vecs[n].expReady);
            checkOutput($sformatf("vec%0d_full", n), full, vecs[n].expFull);
            checkTile($sformatf("vec%0d_out_tile", n), out_tile,
                      (vecs[n].expHeadK < 0) ? '0 : makeTile(vecs[n].expHeadK));
            checkOutput($sformatf("vec%0d_tile_index", n), tile_index, vecs[n].expIdx);
            checkOutput($sformatf("vec%0d_overflow", n), overflow, vecs[n].expOvf);
        end

        // Continue from the table's end state: pointers at 3, write index 19.
        resetModel();
        mWidx = 19;
        mOvf  = 1'b1;
        for (int j = 0; j < 16; j++) stepModel(1, 0, 300 + j);
        stepModel(1, 1, 400);
        checkOutput("full_enq_deq_count", count, 15);
        for (int j = 0; j < 15; j++) stepModel(0, 1, 0);
        stepModel(1, 1, 500);
        checkOutput("empty_enq_deq_count", count, 1);
        checkTile("empty_enq_deq_tile", out_tile, makeTile(500));
        stepModel(0, 1, 0);

        // Mid-operation reset discards tiles and restarts indexing.
        doReset();
        for (int j = 0; j < 5; j++) stepModel(1, 0, 600 + j);
        doReset();
        checkOutput("midrst_count", count, 0);
        checkOutput("midrst_ready", inputs_ready_signal, 0);
        checkOutput("midrst_tile_index", tile_index, 0);
        checkTile("midrst_out_tile", out_tile, '0);
        stepModel(1, 0, 700);
        checkOutput("midrst_first_index", tile_index, 0);
        stepModel(0, 1, 0);

        // Two back-to-back polynomials with continuous popping.
        doReset();
        pdSeen = 0;
        for (int c = 0; c < 128; c++) stepModel(1, mCount > 0, 1000 + c);
        for (int c = 0; c < 40 && mCount > 0; c++) stepModel(0, 1, 0);
        checkOutput("stream_drained", count, 0);
        stepModel(0, 0, 0);
        checkOutput("stream_poly_done_pulses", pdSeen, 2);

        // Random traffic against the model.
        doReset();
        for (int c = 0; c < 1000; c++) begin
            stepModel(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2000 + c);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/poly_tile_fifo.md
Name: poly_tile_fifo

Overview:
- Tile buffer between the polynomial multiplier output and relin_unit.
- Accepts full coefficient tiles from the multiplier, stores up to DEPTH tiles in order, and presents the head tile to relin_unit's poly_mult_outputs with inputs_ready_signal.
- relin_unit pops tiles with its dequeue pulse.
- Tracks each tile's position within a polynomial and flags polynomial completion.

Parameters:
- DATA_WIDTH, 64, coefficient width in bits.
- TILE_WIDTH, 8, coefficients per tile; equals relin_unit RELIN_KEYS_TILE_WIDTH.
- POLY_WIDTH, 512, coefficients per polynomial; must be a multiple of TILE_WIDTH.
- DEPTH, 16, tile entries; power of two, >= 2.
- TILES_PER_POLY (localparam), POLY_WIDTH/TILE_WIDTH = 64.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst, input, 1, asynchronous active-low reset; state clears immediately on negedge, held while low.
- enqueue, input, 1, write strobe from the multiplier.
- in_tile, input, [TILE_WIDTH-1:0][DATA_WIDTH-1:0], tile to write.
- full, output, 1, count == DEPTH.
- out_tile, output, [TILE_WIDTH-1:0][DATA_WIDTH-1:0], head tile; drives relin_unit poly_mult_outputs.
- inputs_ready_signal, output, 1, FIFO non-empty.
- dequeue, input, 1, pop strobe from relin_unit.
- count, output, $clog2(DEPTH)+1, occupied entries.
- tile_index, output, $clog2(TILES_PER_POLY), polynomial-relative index of the head tile.
- last_tile, output, 1, head tile is the last tile of its polynomial.
- poly_done, output, 1, one-cycle pulse.
- overflow, output, 1, sticky error flag.
- underflow, output, 1, sticky error flag.

Behaviour:
- Reset values:
  - Read and write pointers, count, tile_index and both input counters: 0.
  - full, inputs_ready_signal, last_tile, poly_done, overflow, underflow: 0.
  - out_tile: 0.
  - Memory contents are not cleared.
- Storage is show-ahead. When non-empty, out_tile is combinationally mem[rd_ptr]; when empty, out_tile is forced to 0.
- Write: if enqueue && !full at a posedge, store in_tile at wr_ptr and advance wr_ptr modulo DEPTH.
- Write latency: a tile enqueued into an empty FIFO appears on out_tile, with inputs_ready_signal high, in the next cycle.
- Read: if dequeue && inputs_ready_signal at a posedge, advance rd_ptr modulo DEPTH. The next entry, or 0 if now empty, appears in the following cycle.
- count:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - Unchanged when both are accepted in the same cycle.
- Full, enqueue && dequeue together: the write is rejected (full is evaluated before the pop), the read is accepted, and count becomes DEPTH-1.
- Empty, enqueue && dequeue together: the read is ignored, the write is accepted, and count becomes 1. underflow is set.
- enqueue while full (with or without dequeue): the tile is dropped and overflow is set. overflow stays 1 until rst.
- dequeue while empty: no pointer change and underflow is set. underflow stays 1 until rst.
- Tile indexing:
  - An input counter tags each accepted write with widx (0..TILES_PER_POLY-1, wrapping). The tag is stored alongside the tile.
  - tile_index = stored tag of the head entry.
  - last_tile = inputs_ready_signal && (tile_index == TILES_PER_POLY-1).
- poly_done is a registered pulse, high for exactly the one cycle after an accepted read of a tile with last_tile == 1.
- Polynomials stream back-to-back. Indices wrap 63 -> 0 with no gap cycles required.
- Reset mid-operation aborts immediately. All buffered tiles are discarded, count = 0, and index counters restart at 0.

Test Plan:
- Reset, then 3 writes with tile[i] = 64*k + i + 1 for k = 0..2, then 3 single-cycle dequeues -> out_tile shows k = 0, 1, 2 in order, each one cycle after the previous pop. inputs_ready_signal falls the cycle after the third pop; count goes 1, 2, 3, 2, 1, 0.
- Write 16 tiles -> full = 1, count = 16. A 17th enqueue -> overflow = 1 and count stays 16. Dequeue 16 -> the 17th tile is never observed.
- With count = 16, assert enqueue && dequeue for 1 cycle -> count = 15 and overflow = 1. With count = 0, enqueue && dequeue -> count = 1, underflow = 1, and the new tile appears on out_tile next cycle.
- Stream 128 tiles (2 polynomials) with relin_unit dequeuing continuously:
  - tile_index goes 0..63 then 0..63.
  - last_tile is high on indices 63 and 127.
  - poly_done pulses exactly twice, each one cycle after the pop.
  - Pointers wrap 8 times with no data corruption.
- Write 5 tiles, assert rst low for 2 cycles, release -> count = 0, inputs_ready_signal = 0, out_tile = 0, tile_index = 0. The next written tile is reported as index 0.
- 1000 cycles of random enqueue/dequeue at 50% each -> the popped sequence matches the accepted-write sequence, and count always equals accepted writes minus accepted reads, within 0..16.
